// File: rtl/surf_dout_frame_arbiter.sv
// Round-robin, frame-granular merge of NSURF AXI4-Stream channels into one registered output.
// Define FRAME_TIMEOUT_EN to add the stalled-frame watchdog (abort beat, drain, sticky errors).
module surf_dout_frame_arbiter #(
    parameter int NSURF          = 7,
    parameter int DATA_WIDTH     = 8,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int UW = (NSURF > 1) ? $clog2(NSURF) : 1
) (
    input  logic                        sysclk_i,
    input  logic                        rst_i,
    input  logic [NSURF-1:0]            enable_mask_i,
    input  logic [NSURF*DATA_WIDTH-1:0] s_tdata,
    input  logic [NSURF-1:0]            s_tvalid,
    input  logic [NSURF-1:0]            s_tlast,
    output logic [NSURF-1:0]            s_tready,
    output logic [DATA_WIDTH-1:0]       m_tdata,
    output logic                        m_tvalid,
    output logic                        m_tlast,
    output logic [UW-1:0]               m_tuser,
    input  logic                        m_tready,
    output logic                        active_o,
    output logic [CNT_WIDTH-1:0]        frames_o,
    output logic                        timeout_o,
    output logic [NSURF-1:0]            err_o,
    input  logic                        err_clr_i
);

    if (NSURF < 1 || NSURF > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("surf_dout_frame_arbiter: unsupported parameter value");
    end

    typedef enum logic [1:0] {StIdle, StStream, StAbort} state_e;

    state_e                state_q, state_d;
    logic [UW-1:0]         grant_q, grant_d;
    logic [UW-1:0]         last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic                  m_tlast_q, m_tlast_d;
    logic [UW-1:0]         m_tuser_q, m_tuser_d;
    logic [CNT_WIDTH-1:0]  frames_q, frames_d;
    logic [NSURF-1:0]      eligible;
    logic                  load;
    logic                  found;
    int                    idx;

`ifdef FRAME_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
    logic [SW-1:0]    stall_q, stall_d;
    logic [NSURF-1:0] drain_q, drain_d;
    logic [NSURF-1:0] err_q, err_d;
    logic             timeout_q, timeout_d;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
`endif

    always_comb begin
        load         = !m_tvalid_q || m_tready;
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        m_tdata_d    = m_tdata_q;
        m_tvalid_d   = m_tvalid_q;
        m_tlast_d    = m_tlast_q;
        m_tuser_d    = m_tuser_q;
        frames_d     = frames_q;
        s_tready     = '0;
        found        = 1'b0;
        idx          = 0;
        eligible     = s_tvalid & enable_mask_i;
`ifdef FRAME_TIMEOUT_EN
        stall_d   = stall_q;
        drain_d   = drain_q;
        err_d     = err_clr_i ? '0 : err_q;
        timeout_d = 1'b0;
        eligible  = eligible & ~drain_q;
        // Draining channels are sunk unconditionally until their frame ends.
        for (int i = 0; i < NSURF; i++) begin
            if (drain_q[i]) begin
                s_tready[i] = 1'b1;
                if (s_tvalid[i] && s_tlast[i]) drain_d[i] = 1'b0;
            end
        end
`endif
        if (m_tvalid_q && m_tready && m_tlast_q) frames_d = frames_q + CNT_WIDTH'(1);
        if (load) begin
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                for (int k = 1; k <= NSURF; k++) begin
                    idx = (int'(last_grant_q) + k) % NSURF;
                    if (!found && eligible[idx]) begin
                        found   = 1'b1;
                        grant_d = UW'(idx);
                    end
                end
                if (found) begin
                    state_d = StStream;
`ifdef FRAME_TIMEOUT_EN
                    stall_d = '0;
`endif
                end
            end
            StStream: begin
                s_tready[grant_q] = load;
                if (load && s_tvalid[grant_q]) begin
                    m_tdata_d  = s_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
                    m_tvalid_d = 1'b1;
                    m_tlast_d  = s_tlast[grant_q];
                    m_tuser_d  = grant_q;
                    if (s_tlast[grant_q]) begin
                        last_grant_d = grant_q;
                        state_d      = StIdle;
                    end
                end
`ifdef FRAME_TIMEOUT_EN
                // Only source-side stalls count; downstream backpressure never aborts.
                if (load && s_tvalid[grant_q]) begin
                    stall_d = '0;
                end else if (!s_tvalid[grant_q]) begin
                    if (stall_q == SW'(TIMEOUT_CYCLES - 1)) begin
                        stall_d = '0;
                        state_d = StAbort;
                    end else begin
                        stall_d = stall_q + SW'(1);
                    end
                end
`endif
            end
`ifdef FRAME_TIMEOUT_EN
            StAbort: begin
                if (load) begin
                    m_tdata_d        = '0;
                    m_tvalid_d       = 1'b1;
                    m_tlast_d        = 1'b1;
                    m_tuser_d        = grant_q;
                    timeout_d        = 1'b1;
                    err_d[grant_q]   = 1'b1;
                    drain_d[grant_q] = 1'b1;
                    last_grant_d     = grant_q;
                    state_d          = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sysclk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= UW'(NSURF - 1);
            m_tdata_q    <= '0;
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
            m_tuser_q    <= '0;
            frames_q     <= '0;
`ifdef FRAME_TIMEOUT_EN
            stall_q      <= '0;
            drain_q      <= '0;
            err_q        <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            m_tdata_q    <= m_tdata_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tlast_q    <= m_tlast_d;
            m_tuser_q    <= m_tuser_d;
            frames_q     <= frames_d;
`ifdef FRAME_TIMEOUT_EN
            stall_q      <= stall_d;
            drain_q      <= drain_d;
            err_q        <= err_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;
    assign m_tuser  = m_tuser_q;
    assign active_o = (state_q != StIdle);
    assign frames_o = frames_q;
`ifdef FRAME_TIMEOUT_EN
    assign timeout_o = timeout_q;
    assign err_o     = err_q;
`else
    assign timeout_o = 1'b0;
    assign err_o     = '0;
`endif

endmodule
